// File: rtl/picosoc_irqctrl_pkg.sv
// Shared constants for the PicoSoC external interrupt controller:
// register byte offsets, ROUTE field encodings and CLAIM layout.
package picosoc_irqctrl_pkg;

   localparam logic [7:0] OFF_ENABLE   = 8'h00;
   localparam logic [7:0] OFF_PENDING  = 8'h04;
   localparam logic [7:0] OFF_MODE     = 8'h08;
   localparam logic [7:0] OFF_POLARITY = 8'h0C;
   localparam logic [7:0] OFF_ROUTE    = 8'h10;
   localparam logic [7:0] OFF_CLAIM    = 8'h14;
   localparam logic [7:0] OFF_SWTRIG   = 8'h18;

   localparam int unsigned CLAIM_VALID_BIT = 31;

   typedef enum logic [1:0] {
      ROUTE_NONE = 2'd0,
      ROUTE_IRQ5 = 2'd1,
      ROUTE_IRQ6 = 2'd2,
      ROUTE_IRQ7 = 2'd3
   } route_e;

   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] m;
      m = '0;
      for (int unsigned b = 0; b < 4; b++) begin
         m[8*b +: 8] = {8{strb[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/picosoc_irqctrl_sync.sv
// One interrupt source: multi-flop synchronizer, polarity correction and
// rising-edge detect of the corrected (active-high) level.
module picosoc_irqctrl_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic src_i,
   input  logic pol_i,
   output logic active_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
         prev_q <= active_o;
      end
   end

   // Edge is taken after the polarity XOR, so a POLARITY flip can look like an edge.
   assign active_o = sync_q[SYNC_STAGES-1] ^ pol_i;
   assign rise_o   = active_o & ~prev_q;

endmodule

// File: rtl/picosoc_irqctrl.sv
// PicoSoC iomem-mapped external interrupt controller (top).
// Optional macro PICOSOC_IRQCTRL_SWTRIG_EN adds the write-only SWTRIG register at 0x18.
module picosoc_irqctrl
   import picosoc_irqctrl_pkg::*;
#(
   parameter int unsigned NUM_SRC     = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               iomem_valid,
   output logic               iomem_ready,
   input  logic [3:0]         iomem_wstrb,
   input  logic [31:0]        iomem_addr,
   input  logic [31:0]        iomem_wdata,
   output logic [31:0]        iomem_rdata,
   input  logic [NUM_SRC-1:0] src_in,
   output logic [2:0]         irq_out
);

   localparam int unsigned RW = 2 * NUM_SRC;

   logic [NUM_SRC-1:0] enable_q, enable_d, pend_q, pend_d;
   logic [NUM_SRC-1:0] mode_q, mode_d, pol_q, pol_d;
   logic [RW-1:0]      route_q, route_d;
   logic               ready_q, ready_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [2:0]         irq_q, irq_d;

   logic [NUM_SRC-1:0] active, rise, pend_eff, claimable, clr, swset;
   logic               sel, acc, wr, rd;
   logic [5:0]         off;
   logic [31:0]        wmask, wdm;
   logic               claim_vld;
   logic [3:0]         claim_idx;
   logic               unused_bits;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      picosoc_irqctrl_sync #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
         .clk_i   (clk),
         .rst_ni  (resetn),
         .src_i   (src_in[i]),
         .pol_i   (pol_q[i]),
         .active_o(active[i]),
         .rise_o  (rise[i])
      );
   end

   assign sel   = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
   assign acc   = sel && !ready_q;
   assign wr    = acc && (iomem_wstrb != 4'b0000);
   assign rd    = acc && (iomem_wstrb == 4'b0000);
   assign off   = iomem_addr[7:2];
   assign wmask = strb_mask(iomem_wstrb);
   assign wdm   = iomem_wdata & wmask;

   // Level-mode sources bypass the pending flop so they follow the input directly.
   assign pend_eff  = (pend_q & mode_q) | (active & ~mode_q);
   assign claimable = pend_eff & enable_q;

   always_comb begin
      claim_vld = 1'b0;
      claim_idx = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (!claim_vld && claimable[i]) begin
            claim_vld = 1'b1;
            claim_idx = 4'(i);
         end
      end
   end

   always_comb begin
      enable_d = enable_q;
      mode_d   = mode_q;
      pol_d    = pol_q;
      route_d  = route_q;
      clr      = '0;
      swset    = '0;
      rdata_d  = '0;
      if (wr) begin
         case (off)
            OFF_ENABLE[7:2]:   enable_d = (enable_q & ~wmask[NUM_SRC-1:0]) | wdm[NUM_SRC-1:0];
            OFF_PENDING[7:2]:  clr      = wdm[NUM_SRC-1:0];
            OFF_MODE[7:2]:     mode_d   = (mode_q & ~wmask[NUM_SRC-1:0]) | wdm[NUM_SRC-1:0];
            OFF_POLARITY[7:2]: pol_d    = (pol_q & ~wmask[NUM_SRC-1:0]) | wdm[NUM_SRC-1:0];
            OFF_ROUTE[7:2]:    route_d  = (route_q & ~wmask[RW-1:0]) | wdm[RW-1:0];
`ifdef PICOSOC_IRQCTRL_SWTRIG_EN
            OFF_SWTRIG[7:2]:   swset    = wdm[NUM_SRC-1:0];
`else
            OFF_SWTRIG[7:2]:   ;
`endif
            default:           ;
         endcase
      end
      if (rd) begin
         case (off)
            OFF_ENABLE[7:2]:   rdata_d = 32'(enable_q);
            OFF_PENDING[7:2]:  rdata_d = 32'(pend_eff);
            OFF_MODE[7:2]:     rdata_d = 32'(mode_q);
            OFF_POLARITY[7:2]: rdata_d = 32'(pol_q);
            OFF_ROUTE[7:2]:    rdata_d = 32'(route_q);
            OFF_CLAIM[7:2]: begin
               if (claim_vld) begin
                  rdata_d[CLAIM_VALID_BIT] = 1'b1;
                  rdata_d[3:0]             = claim_idx;
                  for (int unsigned i = 0; i < NUM_SRC; i++) begin
                     if (claim_idx == 4'(i)) clr[i] = 1'b1;
                  end
               end
            end
            default:           ;
         endcase
      end
   end

   // New events are ORed in after the clear so a coincident set wins.
   assign pend_d  = mode_q & (rise | swset | (pend_q & ~clr));
   assign ready_d = acc;

   always_comb begin
      irq_d = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (claimable[i]) begin
            case (route_e'(route_q[2*i +: 2]))
               ROUTE_IRQ5: irq_d[0] = 1'b1;
               ROUTE_IRQ6: irq_d[1] = 1'b1;
               ROUTE_IRQ7: irq_d[2] = 1'b1;
               default:    ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         enable_q <= '0;
         pend_q   <= '0;
         mode_q   <= '0;
         pol_q    <= '0;
         route_q  <= '0;
         ready_q  <= 1'b0;
         rdata_q  <= '0;
         irq_q    <= '0;
      end else begin
         enable_q <= enable_d;
         pend_q   <= pend_d;
         mode_q   <= mode_d;
         pol_q    <= pol_d;
         route_q  <= route_d;
         ready_q  <= ready_d;
         rdata_q  <= rdata_d;
         irq_q    <= irq_d;
      end
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign irq_out     = irq_q;

   assign unused_bits = ^{iomem_addr[1:0], wdm, wmask};

endmodule

// File: tb/tb_picosoc_irqctrl.sv
// Self-checking bench for picosoc_irqctrl: behavioural per-source model with
// a per-cycle compare process, directed scenarios and a randomized phase.
module tb_picosoc_irqctrl;

   localparam int          N    = 8;
   localparam int          S    = 2;
   localparam logic [31:0] BASE = 32'h0300_0000;
`ifdef PICOSOC_IRQCTRL_SWTRIG_EN
   localparam logic [31:0] SW_EXP = 32'h0000_0001;
`else
   localparam logic [31:0] SW_EXP = 32'h0000_0000;
`endif

   logic          clk = 1'b0;
   logic          resetn = 1'b1;
   logic          iomem_valid = 1'b0;
   logic          iomem_ready;
   logic [3:0]    iomem_wstrb = '0;
   logic [31:0]   iomem_addr = '0;
   logic [31:0]   iomem_wdata = '0;
   logic [31:0]   iomem_rdata;
   logic [N-1:0]  src_in = '0;
   logic [2:0]    irq_out;

   int tests = 0;
   int fails = 0;
   bit rnd_done = 1'b0;

   picosoc_irqctrl #(
      .NUM_SRC(N),
      .BASE_ADDR(BASE),
      .SYNC_STAGES(S)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .iomem_valid(iomem_valid),
      .iomem_ready(iomem_ready),
      .iomem_wstrb(iomem_wstrb),
      .iomem_addr(iomem_addr),
      .iomem_wdata(iomem_wdata),
      .iomem_rdata(iomem_rdata),
      .src_in(src_in),
      .irq_out(irq_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [N-1:0]   m_hist [S];
   logic [N-1:0]   m_prev = '0, m_en = '0, m_pend = '0, m_mode = '0, m_pol = '0;
   logic [2*N-1:0] m_route = '0;
   logic           m_rdy = 1'b0;
   logic [31:0]    m_rdata = '0;
   logic [2:0]     m_irq = '0;

   logic [N-1:0]   t_act, t_rise, t_peff, t_clr, t_sw;
   logic [31:0]    t_mask, t_rdata;
   logic [2:0]     t_irq;
   bit             t_acc, t_found;
   int             t_word;

   initial for (int k = 0; k < S; k++) m_hist[k] = '0;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < S; k++) m_hist[k] = '0;
         m_prev = '0; m_en = '0; m_pend = '0; m_mode = '0; m_pol = '0;
         m_route = '0; m_rdy = 1'b0; m_rdata = '0; m_irq = '0;
      end else begin
         t_act  = m_hist[S-1] ^ m_pol;
         t_rise = t_act & ~m_prev;
         for (int i = 0; i < N; i++) t_peff[i] = m_mode[i] ? m_pend[i] : t_act[i];
         t_irq = '0;
         for (int i = 0; i < N; i++) begin
            if (t_peff[i] && m_en[i] && m_route[2*i +: 2] != 2'd0)
               t_irq[int'(m_route[2*i +: 2]) - 1] = 1'b1;
         end
         t_acc   = iomem_valid && iomem_addr[31:8] == BASE[31:8] && !m_rdy;
         t_rdata = '0; t_clr = '0; t_sw = '0;
         if (t_acc) begin
            t_word = int'(iomem_addr[7:2]);
            for (int b = 0; b < 4; b++) t_mask[8*b +: 8] = iomem_wstrb[b] ? 8'hFF : 8'h00;
            if (iomem_wstrb == 4'b0000) begin
               case (t_word)
                  0: t_rdata = 32'(m_en);
                  1: t_rdata = 32'(t_peff);
                  2: t_rdata = 32'(m_mode);
                  3: t_rdata = 32'(m_pol);
                  4: t_rdata = 32'(m_route);
                  5: begin
                     t_found = 1'b0;
                     for (int i = 0; i < N; i++) begin
                        if (!t_found && t_peff[i] && m_en[i]) begin
                           t_found = 1'b1;
                           t_rdata = 32'h8000_0000 + 32'(i);
                           t_clr[i] = 1'b1;
                        end
                     end
                  end
                  default: t_rdata = '0;
               endcase
            end else begin
               case (t_word)
                  0: m_en    = (m_en & ~t_mask[N-1:0]) | (iomem_wdata[N-1:0] & t_mask[N-1:0]);
                  1: t_clr   = iomem_wdata[N-1:0] & t_mask[N-1:0];
                  2: ;
                  3: ;
                  4: m_route = (m_route & ~t_mask[2*N-1:0]) | (iomem_wdata[2*N-1:0] & t_mask[2*N-1:0]);
`ifdef PICOSOC_IRQCTRL_SWTRIG_EN
                  6: t_sw    = iomem_wdata[N-1:0] & t_mask[N-1:0];
`endif
                  default: ;
               endcase
            end
         end
         // Edge-mode pending uses the mode in force before this write lands.
         for (int i = 0; i < N; i++)
            m_pend[i] = m_mode[i] && (t_rise[i] || t_sw[i] || (m_pend[i] && !t_clr[i]));
         if (t_acc && iomem_wstrb != 4'b0000 && t_word == 2)
            m_mode = (m_mode & ~t_mask[N-1:0]) | (iomem_wdata[N-1:0] & t_mask[N-1:0]);
         if (t_acc && iomem_wstrb != 4'b0000 && t_word == 3)
            m_pol  = (m_pol & ~t_mask[N-1:0]) | (iomem_wdata[N-1:0] & t_mask[N-1:0]);
         m_prev = t_act;
         for (int k = S-1; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = src_in;
         m_rdy   = t_acc;
         m_rdata = t_rdata;
         m_irq   = t_irq;
      end
   end

   always @(negedge clk) begin
      chk("irq_out", 32'(irq_out), 32'(m_irq));
      chk("ready", 32'(iomem_ready), 32'(m_rdy));
      if (m_rdy) chk("rdata", iomem_rdata, m_rdata);
   end

   // ---------------- bus helpers ----------------
   task automatic bus_start(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd);
      iomem_valid = 1'b1;
      iomem_addr  = a;
      iomem_wstrb = ws;
      iomem_wdata = wd;
   endtask

   task automatic bus_wait(input bit expect_ack, output logic [31:0] rd);
      bit got = 1'b0;
      rd = '0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (iomem_ready) begin
            got = 1'b1;
            rd  = iomem_rdata;
            break;
         end
      end
      iomem_valid = 1'b0;
      iomem_wstrb = '0;
      chk(expect_ack ? "ack" : "no_ack", 32'(got), 32'(expect_ack));
      if (got) begin
         @(negedge clk);
         chk("ready_pulse", 32'(iomem_ready), 32'd0);
      end
   endtask

   task automatic bus(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                      input bit expect_ack, output logic [31:0] rd);
      @(negedge clk);
      bus_start(a, ws, wd);
      bus_wait(expect_ack, rd);
   endtask

   task automatic wr(input logic [7:0] o, input logic [31:0] d);
      logic [31:0] dummy;
      bus(BASE + 32'(o), 4'hF, d, 1'b1, dummy);
   endtask

   task automatic rd(input logic [7:0] o, output logic [31:0] r);
      bus(BASE + 32'(o), 4'h0, 32'h0, 1'b1, r);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      #1 resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_irq", 32'(irq_out), 32'd0);
      chk("reset_ready", 32'(iomem_ready), 32'd0);
      resetn = 1'b1;

      for (int o = 0; o <= 'h14; o += 4) begin
         rd(8'(o), r);
         chk("reset_read", r, 32'h0);
      end

      // Edge source 2 routed to irq_7.
      wr(8'h08, 32'h04);
      wr(8'h00, 32'h04);
      wr(8'h10, 32'h30);
      src_in[2] = 1'b1;
      @(negedge clk);
      src_in[2] = 1'b0;
      @(posedge clk);
      @(posedge clk); #1 chk("edge_lat3", 32'(irq_out), 32'h0);
      @(posedge clk); #1 chk("edge_lat4", 32'(irq_out), 32'h4);
      rd(8'h14, r);
      chk("claim_src2", r, 32'h8000_0002);
      chk("irq_after_claim", 32'(irq_out), 32'h0);

      // Level source 0, active-low, routed to irq_5.
      wr(8'h0C, 32'h01);
      wr(8'h10, 32'h31);
      wr(8'h00, 32'h05);
      repeat (3) @(negedge clk);
      chk("level_on", 32'(irq_out), 32'h1);
      wr(8'h04, 32'h01);
      chk("level_w1c_noeff", 32'(irq_out), 32'h1);
      rd(8'h04, r);
      chk("level_pending", r, 32'h01);
      src_in[0] = 1'b1;
      @(posedge clk);
      @(posedge clk); #1 chk("level_off2", 32'(irq_out), 32'h1);
      @(posedge clk); #1 chk("level_off3", 32'(irq_out), 32'h0);

      // Edge on src 5 coincides with W1C of the same bit.
      @(negedge clk);
      src_in = '0;
      wr(8'h0C, 32'h00);
      wr(8'h08, 32'hFF);
      repeat (4) @(negedge clk);
      wr(8'h04, 32'hFF);
      src_in[5] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus_start(BASE + 32'h04, 4'hF, 32'h20);
      bus_wait(1'b1, r);
      rd(8'h04, r);
      chk("set_beats_clear", r, 32'h20);

      // Two sources claimed in order, then empty.
      src_in[5] = 1'b0;
      wr(8'h00, 32'h48);
      src_in[3] = 1'b1; src_in[6] = 1'b1;
      @(negedge clk);
      src_in[3] = 1'b0; src_in[6] = 1'b0;
      repeat (4) @(negedge clk);
      rd(8'h14, r); chk("claim_3", r, 32'h8000_0003);
      rd(8'h14, r); chk("claim_6", r, 32'h8000_0006);
      rd(8'h14, r); chk("claim_none", r, 32'h0);
      bus(32'h0400_0000, 4'h0, 32'h0, 1'b0, r);
      bus(BASE + 32'h40, 4'hF, 32'hFFFF_FFFF, 1'b1, r);
      bus(BASE + 32'h40, 4'h0, 32'h0, 1'b1, r);
      chk("unmapped_read", r, 32'h0);
      rd(8'h00, r); chk("enable_kept", r, 32'h48);

      // Software trigger on edge source 0.
      wr(8'h04, 32'hFF);
      wr(8'h18, 32'h01);
      rd(8'h04, r);
      chk("swtrig", r, SW_EXP);

      // Randomized traffic against the model.
      fork
         begin
            while (!rnd_done) begin
               @(negedge clk);
               if ($urandom_range(0, 3) == 0) begin
                  int j;
                  j = int'($urandom_range(0, N-1));
                  src_in[j] = ~src_in[j];
               end
            end
         end
         begin
            for (int n = 0; n < 300; n++) begin
               logic [31:0] a;
               logic [3:0]  ws;
               int          sel;
               a   = BASE + 32'($urandom_range(0, 7) * 4);
               sel = int'($urandom_range(0, 9));
               if (sel == 0) a = 32'h0400_0000 | {24'h0, a[7:0]};
               if (sel == 1) a = BASE + 32'h40;
               ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
               bus(a, ws, $urandom, sel != 0, r);
               repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            rnd_done = 1'b1;
         end
      join

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
